// File: rtl/sim_run_ctrl_pkg.sv
// Shared types and constants for the simulation run controller (package sim_ctrl_pkg).
// Holds the FSM state encoding, heartbeat period and status codes.
`timescale 1ns/1ps
package sim_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int HB_PERIOD = 64;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET   = 3'd0,
    ST_STAGGER = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_BUSY    = 2'd0;
  localparam logic [1:0] STATUS_DONE    = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

  // Summarise a state as a bench-facing status code.
  function automatic logic [1:0] status_of(input state_e st);
    case (st)
      ST_DONE:    status_of = STATUS_DONE;
      ST_TIMEOUT: status_of = STATUS_TIMEOUT;
      default:    status_of = STATUS_BUSY;
    endcase
  endfunction

endpackage

// File: rtl/sim_rst_stagger.sv
// Staggered per-domain reset release: one edge counter plus a reset register per domain.
// last_rel is high during the cycle whose closing edge releases the final domain.
`timescale 1ns/1ps
module sim_rst_stagger #(
  parameter int NUM_DOMAINS    = 2,
  parameter int RST_CYCLES     = 25,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [NUM_DOMAINS-1:0] rst_dom,
  output logic                   last_rel
);

  localparam int LAST_EDGE = RST_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CW        = $clog2(LAST_EDGE + 1);

  // Counts edges since rst went low, parking at the final release edge.
  logic [CW-1:0] edge_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      rst_dom  <= '1;
    end else begin
      if (32'(edge_cnt) != LAST_EDGE) begin
        edge_cnt <= edge_cnt + CW'(1);
      end
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        if (32'(edge_cnt) >= RST_CYCLES + k * STAGGER_CYCLES - 1) begin
          rst_dom[k] <= 1'b0;
        end
      end
    end
  end

  assign last_rel = (32'(edge_cnt) == LAST_EDGE - 1);

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: staggered reset, run cycle counter, halt detect, watchdog, dump window.
// Optional heartbeat pulse enabled by defining SIM_RUN_CTRL_HEARTBEAT_EN.
`timescale 1ns/1ps
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS    = 2,
  parameter int RST_CYCLES     = 25,
  parameter int STAGGER_CYCLES = 4,
  parameter int MAX_CYCLES     = 250,
  parameter int CNT_W          = 32,
  parameter int DUMP_START     = 0,
  parameter int DUMP_END       = 250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt_i,
  output logic [NUM_DOMAINS-1:0] rst_dom_o,
  output logic                   run_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [CNT_W-1:0]       cycle_cnt_o,
  output logic                   dump_en_o,
  output logic                   heartbeat_o
);

  localparam logic [63:0] DS64  = 64'(DUMP_START);
  localparam logic [63:0] DE64  = 64'(DUMP_END);
  localparam logic [63:0] MAX64 = 64'(MAX_CYCLES);

  state_e           state;
  logic             last_rel;
  logic [CNT_W-1:0] cnt_inc;
  logic             to_hit;

  sim_rst_stagger #(
    .NUM_DOMAINS   (NUM_DOMAINS),
    .RST_CYCLES    (RST_CYCLES),
    .STAGGER_CYCLES(STAGGER_CYCLES)
  ) u_stagger (
    .clk     (clk),
    .rst     (rst),
    .rst_dom (rst_dom_o),
    .last_rel(last_rel)
  );

  // Borrow-based lower bound avoids a constant compare when DUMP_START is 0.
  function automatic logic in_window(input logic [CNT_W-1:0] c);
    logic [64:0] diff;
    diff      = {1'b0, 64'(c)} - {1'b0, DS64};
    in_window = !diff[64] && (64'(c) < DE64);
  endfunction

  assign cnt_inc = (cycle_cnt_o == {CNT_W{1'b1}}) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);
  assign to_hit  = (MAX_CYCLES != 0) && (64'(cycle_cnt_o) == MAX64 - 64'd1);

`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
  logic hb;
  assign heartbeat_o = hb;
`else
  assign heartbeat_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RESET;
      run_o       <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      cycle_cnt_o <= '0;
      dump_en_o   <= 1'b0;
`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
      hb          <= 1'b0;
`endif
    end else begin
`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
      hb <= 1'b0;
`endif
      case (state)
        ST_RESET, ST_STAGGER: begin
          if (last_rel) begin
            state       <= ST_RUN;
            run_o       <= 1'b1;
            cycle_cnt_o <= '0;
            dump_en_o   <= in_window('0);
          end else if (!rst_dom_o[0]) begin
            state <= ST_STAGGER;
          end
        end
        ST_RUN: begin
          cycle_cnt_o <= cnt_inc;
          if (halt_i) begin
            state     <= ST_DONE;
            run_o     <= 1'b0;
            done_o    <= 1'b1;
            dump_en_o <= 1'b0;
          end else if (to_hit) begin
            state     <= ST_TIMEOUT;
            run_o     <= 1'b0;
            timeout_o <= 1'b1;
            dump_en_o <= 1'b0;
          end else begin
            dump_en_o <= in_window(cnt_inc);
`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
            // Only pulse on an actual increment so a saturated counter cannot stick high.
            hb <= (cnt_inc != cycle_cnt_o) && ((64'(cnt_inc) % 64'(HB_PERIOD)) == 64'd0);
`endif
          end
        end
        ST_DONE, ST_TIMEOUT: begin
          state <= state;
        end
        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: default instance plus a narrow-counter, three-domain instance.
`timescale 1ns/1ps
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic [1:0]  rst_dom;
  logic        run, done, timeout, dump_en, hb;
  logic [31:0] cnt;
  logic [2:0]  rst_dom2;
  logic        run2, done2, timeout2, dump_en2, hb2;
  logic [3:0]  cnt2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sim_run_ctrl dut (
    .clk(clk), .rst(rst), .halt_i(halt), .rst_dom_o(rst_dom), .run_o(run),
    .done_o(done), .timeout_o(timeout), .cycle_cnt_o(cnt), .dump_en_o(dump_en),
    .heartbeat_o(hb)
  );

  sim_run_ctrl #(
    .NUM_DOMAINS(3), .STAGGER_CYCLES(0), .MAX_CYCLES(0), .CNT_W(4)
  ) dut2 (
    .clk(clk), .rst(rst), .halt_i(1'b0), .rst_dom_o(rst_dom2), .run_o(run2),
    .done_o(done2), .timeout_o(timeout2), .cycle_cnt_o(cnt2), .dump_en_o(dump_en2),
    .heartbeat_o(hb2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; inputs change and outputs are sampled 1ns after each edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: reset then staggered release
    tick(10);
    chk("rst_dom_reset", 64'(rst_dom), 64'h3);
    chk("run_reset", 64'(run), 64'h0);
    chk("cnt_reset", cnt, 64'h0);
    chk("dump_reset", 64'(dump_en), 64'h0);
    rst = 1'b0;
    tick(24);
    chk("rst_dom_e24", 64'(rst_dom), 64'h3);
    chk("rst_dom2_e24", 64'(rst_dom2), 64'h7);
    tick(1);
    chk("rst_dom_e25", 64'(rst_dom), 64'h2);
    chk("run_e25", 64'(run), 64'h0);
    chk("rst_dom2_e25", 64'(rst_dom2), 64'h0);
    chk("run2_e25", 64'(run2), 64'h1);
    tick(3);
    chk("rst_dom_e28", 64'(rst_dom), 64'h2);
    chk("run_e28", 64'(run), 64'h0);
    tick(1);
    chk("rst_dom_e29", 64'(rst_dom), 64'h0);
    chk("run_e29", 64'(run), 64'h1);
    chk("cnt_e29", cnt, 64'h0);
    chk("dump_e29", 64'(dump_en), 64'h1);

    // Test 2: halt at 100; also narrow instance saturates
    tick(100);
    chk("cnt_100", cnt, 64'd100);
    chk("cnt2_sat", 64'(cnt2), 64'd15);
    chk("run2_sat", 64'(run2), 64'h1);
    chk("timeout2_off", 64'(timeout2), 64'h0);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("done_halt", 64'(done), 64'h1);
    chk("cnt_halt", cnt, 64'd101);
    chk("run_halt", 64'(run), 64'h0);
    chk("timeout_halt", 64'(timeout), 64'h0);
    tick(5);
    chk("cnt_frozen", cnt, 64'd101);
    chk("done_sticky", 64'(done), 64'h1);
    chk("rst_dom_done", 64'(rst_dom), 64'h0);

    // Test 3: no halt -> timeout at 250, heartbeat at 64
    rst = 1'b1;
    tick(1);
    chk("done_cleared", 64'(done), 64'h0);
    chk("cnt_cleared", cnt, 64'h0);
    chk("rst_dom_re", 64'(rst_dom), 64'h3);
    rst = 1'b0;
    tick(29);
    chk("run_t3", 64'(run), 64'h1);
    tick(63);
    chk("hb_63", 64'(hb), 64'h0);
    tick(1);
    chk("cnt_64", cnt, 64'd64);
`ifdef SIM_RUN_CTRL_HEARTBEAT_EN
    chk("hb_64", 64'(hb), 64'h1);
`else
    chk("hb_64", 64'(hb), 64'h0);
`endif
    tick(1);
    chk("hb_65", 64'(hb), 64'h0);
    tick(184);
    chk("cnt_249", cnt, 64'd249);
    chk("dump_249", 64'(dump_en), 64'h1);
    chk("run_249", 64'(run), 64'h1);
    tick(1);
    chk("cnt_250", cnt, 64'd250);
    chk("timeout_250", 64'(timeout), 64'h1);
    chk("run_250", 64'(run), 64'h0);
    chk("dump_250", 64'(dump_en), 64'h0);
    chk("done_250", 64'(done), 64'h0);

    // Test 4: halt at 249 wins over timeout
    rst = 1'b1;
    tick(1);
    chk("timeout_cleared", 64'(timeout), 64'h0);
    rst = 1'b0;
    tick(29);
    tick(249);
    chk("cnt_t4", cnt, 64'd249);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    chk("done_prio", 64'(done), 64'h1);
    chk("timeout_prio", 64'(timeout), 64'h0);
    chk("cnt_prio", cnt, 64'd250);

    // Test 5: rst mid-run then identical resequence; halt ignored before RUN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(29);
    tick(60);
    chk("cnt_60", cnt, 64'd60);
    rst = 1'b1;
    tick(1);
    chk("rst_dom_mid", 64'(rst_dom), 64'h3);
    chk("cnt_mid", cnt, 64'h0);
    chk("run_mid", 64'(run), 64'h0);
    rst = 1'b0;
    halt = 1'b1;
    tick(24);
    halt = 1'b0;
    chk("rst_dom_r24", 64'(rst_dom), 64'h3);
    chk("done_ignored", 64'(done), 64'h0);
    tick(1);
    chk("rst_dom_r25", 64'(rst_dom), 64'h2);
    tick(4);
    chk("rst_dom_r29", 64'(rst_dom), 64'h0);
    chk("run_r29", 64'(run), 64'h1);
    chk("cnt_r29", cnt, 64'h0);
    chk("done_r29", 64'(done), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
